// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared types and constants for the 6502 shared-bus controllers.
//   dma_state_t   : sprite-DMA sequencer states
//   PPU_REG_BASE  : first address of the PPU register window ($2000-$3FFF)
//   PPU_REG_MASK  : value of cpu_addr[15:13] that selects the PPU window
//   OAMDMA_ADDR   : CPU address whose write starts a sprite DMA
//   OAMDATA_IDX   : PPU register index of OAMDATA
package nes_bus_pkg;

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} dma_state_t;

  localparam logic [15:0] PPU_REG_BASE = 16'h2000;
  localparam logic [2:0]  PPU_REG_MASK = 3'b001;
  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [2:0]  OAMDATA_IDX  = 3'd4;

endpackage

// File: rtl/oam_dma_ctrl_ppu_reg_decode.sv
// ppu_reg_decode: combinational CPU address decode for the PPU register port.
//   cpu_addr  in  16  CPU address bus
//   cs_n      out 1   PPU register chip select, active low ($2000-$3FFF, mirrored every 8)
//   reg_addr  out 3   PPU register index
module ppu_reg_decode
  import nes_bus_pkg::*;
(
  input  logic [15:0] cpu_addr,
  output logic        cs_n,
  output logic [2:0]  reg_addr
);

  // Middle address bits are don't-care: the eight PPU registers mirror across the window.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[12:3];

  assign cs_n     = (cpu_addr[15:13] != PPU_REG_MASK);
  assign reg_addr = cpu_addr[2:0];

endmodule

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite-DMA sequencer between the 6502 core and the shared bus.
// A CPU write of a page number to DMA_REG_ADDR suspends the core (cpu_rdy=0) and copies
// XFER_LEN bytes from WRAM {page,idx} into PPU OAMDATA, then returns the bus.
// When idle, CPU traffic passes straight through and the PPU chip select is decoded.
// Optional feature macro: OAMDMA_ALIGN_EN -- when defined, a HALT that lands on an odd
// CPU cycle (parity==1) is followed by one ALIGN cycle; when undefined there is no
// parity flop and the stall is always 1+2*XFER_LEN cycles.
// Ports:
//   clk, nreset                         clock, synchronous active-low reset
//   cpu_addr, cpu_dout, cpu_we          CPU bus inputs
//   cpu_rdy                             CPU ready; 0 suspends the core
//   bus_addr, bus_we, bus_din           WRAM port (bus_din valid the cycle after bus_addr)
//   ppu_reg_cs, ppu_reg_addr, ppu_we,
//   ppu_dout                            PPU register port (cs active low)
//   dma_active                          high from HALT through the last WRITE
//
// state | meaning
// IDLE  | CPU owns the bus, waiting for a DMA_REG_ADDR write
// HALT  | core suspended, first DMA cycle
// ALIGN | spare cycle to re-align to an even CPU cycle (OAMDMA_ALIGN_EN only)
// READ  | WRAM read of {page,idx}
// WRITE | previous read data written to OAMDATA, idx advances
// DONE  | core released, one cycle before IDLE
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAMDMA_ADDR,
  parameter logic [2:0]  OAM_DATA_REG = OAMDATA_IDX,
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  input  logic [7:0]  bus_din,
  output logic        ppu_reg_cs,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_we,
  output logic [7:0]  ppu_dout,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic       cpu_rdy_q, cpu_rdy_d;
  logic       dma_active_q, dma_active_d;

`ifdef OAMDMA_ALIGN_EN
  logic parity_q, parity_d;
  assign parity_d = ~parity_q;
`endif

  logic       dec_cs_n;
  logic [2:0] dec_reg_addr;

  ppu_reg_decode u_ppu_reg_decode (
    .cpu_addr (cpu_addr),
    .cs_n     (dec_cs_n),
    .reg_addr (dec_reg_addr)
  );

  logic trigger;
  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    page_d       = page_q;
    cpu_rdy_d    = cpu_rdy_q;
    dma_active_d = dma_active_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d       = cpu_dout;
          idx_d        = '0;
          state_d      = HALT;
          cpu_rdy_d    = 1'b0;
          dma_active_d = 1'b1;
        end
      end
      HALT: begin
`ifdef OAMDMA_ALIGN_EN
        state_d = parity_q ? ALIGN : READ;
`else
        state_d = READ;
`endif
      end
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          // Explicit wrap keeps idx at 0 between transfers even for XFER_LEN < 256.
          idx_d        = '0;
          state_d      = DONE;
          cpu_rdy_d    = 1'b1;
          dma_active_d = 1'b0;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      page_q       <= '0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
`ifdef OAMDMA_ALIGN_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
`ifdef OAMDMA_ALIGN_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // DONE already has the core running again, so it shares the pass-through path with IDLE.
  logic pass_through;
  assign pass_through = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    if (pass_through) begin
      bus_addr     = cpu_addr;
      // Writes aimed at the PPU window or the DMA trigger register never reach WRAM.
      bus_we       = cpu_we && dec_cs_n && (cpu_addr != DMA_REG_ADDR);
      ppu_reg_cs   = dec_cs_n;
      ppu_reg_addr = dec_reg_addr;
      ppu_we       = cpu_we && !dec_cs_n;
      ppu_dout     = cpu_dout;
    end else begin
      bus_addr     = {page_q, idx_q};
      bus_we       = 1'b0;
      ppu_reg_cs   = (state_q != WRITE);
      ppu_reg_addr = OAM_DATA_REG;
      ppu_we       = (state_q == WRITE);
      ppu_dout     = bus_din;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: idle pass-through table, directed DMA sequences
// and randomized DMAs with CPU junk on the bus, checked against a transfer-level model.
module tb_oam_dma_ctrl;

`ifdef OAMDMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam int XFER = 256;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_din = 8'h00;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_we;
  logic [7:0]  ppu_dout;
  logic        dma_active;

  oam_dma_ctrl dut (
    .clk          (clk),
    .nreset       (nreset),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .cpu_we       (cpu_we),
    .cpu_rdy      (cpu_rdy),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_din      (bus_din),
    .ppu_reg_cs   (ppu_reg_cs),
    .ppu_reg_addr (ppu_reg_addr),
    .ppu_we       (ppu_we),
    .ppu_dout     (ppu_dout),
    .dma_active   (dma_active)
  );

  always #5 clk = ~clk;

  // WRAM model: address seen during a cycle, data returned in the following cycle.
  logic [7:0]  mem [0:65535];
  logic [15:0] wram_addr_s = 16'h0000;
  always @(negedge clk) wram_addr_s <= bus_addr;
  always @(posedge clk) bus_din <= mem[wram_addr_s];

  // CPU cycle count since reset; its LSB is the get/put parity.
  int pcnt = 0;
  always @(posedge clk) begin
    if (!nreset) pcnt <= 0;
    else         pcnt <= pcnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        exp_cs;
    logic [2:0]  exp_reg;
    logic        exp_pwe;
    logic        exp_bwe;
  } idle_vec_t;

  idle_vec_t tbl [8];

  task automatic idle_check(input string tag, input logic [15:0] a, input logic [7:0] d,
                            input logic w, input logic e_cs, input logic [2:0] e_reg,
                            input logic e_pwe, input logic e_bwe);
    @(posedge clk); #1;
    cpu_addr = a; cpu_dout = d; cpu_we = w;
    @(negedge clk);
    chk({tag, ".cs"},       32'(ppu_reg_cs),   32'(e_cs));
    chk({tag, ".reg"},      32'(ppu_reg_addr), 32'(e_reg));
    chk({tag, ".ppu_we"},   32'(ppu_we),       32'(e_pwe));
    chk({tag, ".bus_we"},   32'(bus_we),       32'(e_bwe));
    chk({tag, ".ppu_dout"}, 32'(ppu_dout),     32'(d));
    chk({tag, ".bus_addr"}, 32'(bus_addr),     32'(a));
    chk({tag, ".cpu_rdy"},  32'(cpu_rdy),      32'd1);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
  endtask

  // Model of idle decode from the address map, not from bit slices of the RTL.
  task automatic idle_random(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        w;
      logic        in_ppu;
      a = 16'($urandom);
      d = 8'($urandom);
      w = 1'($urandom);
      if (w && a == 16'h4014) a = 16'h4015;
      in_ppu = (a >= 16'h2000) && (a <= 16'h3FFF);
      idle_check("idle_rand", a, d, w, !in_ppu, 3'(a % 8), w && in_ppu,
                 w && !in_ppu && (a != 16'h4014));
    end
  endtask

  // Triggers one DMA and watches it until cpu_rdy returns.
  // mode 0: quiet CPU bus; 1: random CPU junk; 2: one $4014<=07 write in stall cycle 50.
  // want_par: required parity in the HALT cycle, or -1 for don't care.
  // rst_at: assert reset at the end of this numbered OAMDATA write (0 = never).
  task automatic run_dma(input logic [7:0] pg, input int mode, input int want_par,
                         input int rst_at, output int stall, output int nwr,
                         output bit par_halt);
    int bad_we, bad_pg, bad_data, bad_reg;
    logic [15:0] max_a;
    bit finished;
    stall = 0; nwr = 0; par_halt = 1'b0;
    bad_we = 0; bad_pg = 0; bad_data = 0; bad_reg = 0;
    max_a = 16'h0000; finished = 1'b0;
    @(posedge clk); #1;
    if (want_par >= 0 && pcnt[0] == want_par[0]) begin
      @(posedge clk); #1;
    end
    cpu_addr = 16'h4014; cpu_dout = pg; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (cpu_rdy) begin
        finished = 1'b1;
        break;
      end
      if (stall == 0) par_halt = pcnt[0];
      stall++;
      if (bus_we) bad_we++;
      if (bus_addr[15:8] != pg) bad_pg++;
      if (bus_addr > max_a) max_a = bus_addr;
      if (!ppu_reg_cs && ppu_we) begin
        if (ppu_reg_addr != 3'd4) bad_reg++;
        if (ppu_dout != mem[{pg, 8'(nwr)}]) bad_data++;
        nwr++;
        if (rst_at != 0 && nwr == rst_at) begin
          #1 nreset = 1'b0;
        end
      end
      @(posedge clk); #1;
      cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
      if (mode == 1) begin
        if ($urandom_range(0, 7) == 0) begin
          cpu_addr = 16'h4014; cpu_dout = 8'h07; cpu_we = 1'b1;
        end else begin
          cpu_addr = 16'($urandom); cpu_dout = 8'($urandom); cpu_we = 1'($urandom);
        end
      end else if (mode == 2 && stall == 50) begin
        cpu_addr = 16'h4014; cpu_dout = 8'h07; cpu_we = 1'b1;
      end
    end
    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
    chk("dma_finished", 32'(finished), 32'd1);
    chk("dma_bus_we_low", 32'(bad_we), 32'd0);
    chk("dma_page", 32'(bad_pg), 32'd0);
    chk("dma_oam_reg", 32'(bad_reg), 32'd0);
    chk("dma_data", 32'(bad_data), 32'd0);
    if (rst_at == 0) chk("dma_last_addr", 32'(max_a), 32'({pg, 8'hFF}));
  endtask

  function automatic int exp_stall(bit par);
    return 1 + 2 * XFER + ((ALIGN_EN && par) ? 1 : 0);
  endfunction

  initial begin
    int  stall, nwr;
    bit  par;

    for (int a = 0; a < 65536; a++)
      mem[a] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'hA5) : 8'($urandom);

    tbl[0] = '{16'h2001, 8'h1E, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
    tbl[1] = '{16'h0000, 8'h55, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[2] = '{16'h3FFF, 8'hAA, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[3] = '{16'h4014, 8'h12, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    tbl[4] = '{16'h4013, 8'h34, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1};
    tbl[5] = '{16'h1FFF, 8'h01, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1};
    tbl[6] = '{16'h4000, 8'h77, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[7] = '{16'h2000, 8'h99, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    // Reset state, then a trigger held during reset must not start a DMA.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst.dma_active", 32'(dma_active), 32'd0);
    chk("rst.ppu_reg_cs", 32'(ppu_reg_cs), 32'd1);
    chk("rst.ppu_we", 32'(ppu_we), 32'd0);
    chk("rst.bus_we", 32'(bus_we), 32'd0);
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_dout = 8'h02; cpu_we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_trig.cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_trig.dma_active", 32'(dma_active), 32'd0);
    @(posedge clk); #1;
    cpu_addr = 16'h0000; cpu_we = 1'b0; nreset = 1'b1;

    for (int i = 0; i < 8; i++)
      idle_check("idle_tbl", tbl[i].addr, tbl[i].dout, tbl[i].we, tbl[i].exp_cs,
                 tbl[i].exp_reg, tbl[i].exp_pwe, tbl[i].exp_bwe);

    // Page 2 copy, each parity of the HALT cycle.
    run_dma(8'h02, 0, 0, 0, stall, nwr, par);
    chk("p2_even.stall", 32'(stall), 32'(exp_stall(par)));
    chk("p2_even.nwr", 32'(nwr), 32'(XFER));
    run_dma(8'h02, 0, 1, 0, stall, nwr, par);
    chk("p2_odd.stall", 32'(stall), 32'(exp_stall(par)));
    chk("p2_odd.nwr", 32'(nwr), 32'(XFER));

    // Top page, then the bus must be back in pass-through.
    run_dma(8'hFF, 0, -1, 0, stall, nwr, par);
    chk("pFF.stall", 32'(stall), 32'(exp_stall(par)));
    chk("pFF.nwr", 32'(nwr), 32'(XFER));
    idle_check("after_dma", 16'h2004, 8'h3C, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);

    // Re-trigger mid-transfer is ignored.
    run_dma(8'h02, 2, -1, 0, stall, nwr, par);
    chk("retrig.stall", 32'(stall), 32'(exp_stall(par)));
    chk("retrig.nwr", 32'(nwr), 32'(XFER));

    // Reset at the 100th write, then a fresh DMA starts from idx 0.
    run_dma(8'h02, 0, -1, 100, stall, nwr, par);
    chk("mid_rst.nwr", 32'(nwr), 32'd100);
    chk("mid_rst.cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("mid_rst.ppu_reg_cs", 32'(ppu_reg_cs), 32'd1);
    chk("mid_rst.dma_active", 32'(dma_active), 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    run_dma(8'h03, 0, -1, 0, stall, nwr, par);
    chk("post_rst.stall", 32'(stall), 32'(exp_stall(par)));
    chk("post_rst.nwr", 32'(nwr), 32'(XFER));

    // Randomized DMAs with CPU junk and random idle gaps.
    for (int t = 0; t < 6; t++) begin
      logic [7:0] pg;
      pg = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_dma(pg, 1, -1, 0, stall, nwr, par);
      chk("rand.stall", 32'(stall), 32'(exp_stall(par)));
      chk("rand.nwr", 32'(nwr), 32'(XFER));
    end

    idle_random(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
